// File: rtl/uart_pkg.sv
// uart_pkg: FSM state type, data width and baud divisor helper shared by uart_rx
package uart_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received byte and status pulses
interface uart_rx_if;
  logic rx;
  logic [uart_pkg::DATA_W-1:0] rx_data;
  logic rx_valid, frame_err, parity_err, rx_busy;
  modport master (output rx, input rx_data, rx_valid, frame_err, parity_err, rx_busy);
  modport slave (input rx, output rx_data, rx_valid, frame_err, parity_err, rx_busy);
endinterface

// File: rtl/uart_rx_baud_gen.sv
// uart_rx_baud_gen: oversample tick divider, one pulse every DIV clocks, restartable by clr_i
module uart_rx_baud_gen #(
  parameter int DIV = 54
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == W'(DIV - 1);
  // restart on clear so tick phase follows the start edge, wrap after the terminal count
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8-bit UART receiver; define UART_RX_PARITY_EN for an even parity bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input logic      sys_clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic prev_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic rx_s, fall, tick, sample;
`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d, pbad_q, pbad_d;
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;
  assign sample = tick && tcnt_q == (state_q == START ? MID : LAST);
  assign bus.rx_data = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_busy = state_q != IDLE;
  uart_rx_baud_gen #(.DIV(DIV)) u_baud (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == IDLE && fall),
    .tick_o (tick)
  );
  // frame sequencing: every bit after the start is sampled one full bit after the previous mid-bit sample
  always_comb begin
    state_d = state_q;
    tcnt_d = tick ? tcnt_q + 1'b1 : tcnt_q;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d = 1'b0;
    pbad_d = pbad_q;
`endif
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        tcnt_d = '0;
      end
      START: if (sample) begin
        state_d = rx_s ? IDLE : DATA;
        tcnt_d = '0;
        bit_d = '0;
      end
      DATA: if (sample) begin
        shift_d = {rx_s, shift_q[DATA_W-1:1]};
        tcnt_d = '0;
        bit_d = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == BW'(DATA_W - 1)) state_d = PARITY;
`else
        if (bit_q == BW'(DATA_W - 1)) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (sample) begin
        pbad_d = rx_s ^ (^shift_q);
        tcnt_d = '0;
        state_d = STOP;
      end
`endif
      STOP: if (sample) begin
        state_d = rx_s ? IDLE : WAIT_IDLE;
        valid_d = rx_s;
        ferr_d = ~rx_s;
        data_d = rx_s ? shift_q : data_q;
`ifdef UART_RX_PARITY_EN
        perr_d = rx_s & pbad_q;
`endif
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, datapath and synchronizer registers; reset drops any partial frame
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      tcnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
      pbad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[0], bus.rx};
      prev_q <= rx_s;
      tcnt_q <= tcnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q <= perr_d;
      pbad_q <= pbad_d;
`endif
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx checked against a frame-level event model
module tb_uart_rx;
  localparam int BIT = 864;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = PAR_EN ? 11 : 10;
  typedef struct {
    bit is_err;
    logic [7:0] data;
    bit perr;
    int lo;
    int hi;
  } ev_t;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_if bus ();
  uart_rx dut (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus));
  ev_t exp_q[$];
  ev_t got_e;
  ev_t brk_e;
  logic [7:0] model_data = 8'h00;
  int cyc = 0, checks = 0, errors = 0, n_valid = 0, n_ferr = 0, n_perr = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // compare process: every pulse must match the next modelled frame outcome inside its stop-bit window
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_data = 8'h00;
      checks++;
      if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.parity_err, bus.rx_busy} !== 12'h0) begin
        errors++;
        $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b perr=%b busy=%b, need all 0",
                 bus.rx_data, bus.rx_valid, bus.frame_err, bus.parity_err, bus.rx_busy);
      end
    end else begin
      if (bus.rx_valid) n_valid++;
      if (bus.frame_err) n_ferr++;
      if (bus.parity_err) n_perr++;
      if (bus.rx_valid || bus.frame_err || bus.parity_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got valid=%b ferr=%b perr=%b at cycle %0d, need no pulse",
                   bus.rx_valid, bus.frame_err, bus.parity_err, cyc);
        end else begin
          got_e = exp_q.pop_front();
          if (!got_e.is_err) model_data = got_e.data;
          if (bus.rx_valid !== ~got_e.is_err || bus.frame_err !== got_e.is_err ||
              bus.parity_err !== got_e.perr || cyc < got_e.lo || cyc >= got_e.hi) begin
            errors++;
            $display("FAIL frame_event: got valid=%b ferr=%b perr=%b at cycle %0d, need valid=%b ferr=%b perr=%b in [%0d,%0d)",
                     bus.rx_valid, bus.frame_err, bus.parity_err, cyc,
                     ~got_e.is_err, got_e.is_err, got_e.perr, got_e.lo, got_e.hi);
          end
        end
      end
      checks++;
      if (bus.rx_data !== model_data) begin
        errors++;
        $display("FAIL rx_data_hold: got %h at cycle %0d, need %h", bus.rx_data, cyc, model_data);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, need %0h", name, got, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    bus.rx = v;
    repeat (BIT) @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    ev_t e;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (PAR_EN) bit_time((^d) ^ bad_par);
    e.is_err = !stop;
    e.data = d;
    e.perr = PAR_EN && stop && bad_par;
    e.lo = cyc;
    e.hi = cyc + BIT;
    exp_q.push_back(e);
    bit_time(stop);
  endtask

  initial begin
    int v0, f0, p0;
    logic [7:0] part;
    bus.rx = 1'b1;
    part = 8'hE7;
    repeat (4) @(negedge sys_clk);
    #2 rst_n = 1'b1;
    idle(20);
    chk("idle_busy", 32'(bus.rx_busy), 0);
    chk("idle_data", 32'(bus.rx_data), 0);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_busy_after_stop", 32'(bus.rx_busy), 0);
    idle(BIT);
    chk("a5_data", 32'(bus.rx_data), 'hA5);
    chk("a5_valid_count", n_valid - v0, 1);
    chk("a5_ferr_count", n_ferr - f0, 0);
    chk("a5_drained", exp_q.size(), 0);

    v0 = n_valid; f0 = n_ferr;
    bus.rx = 1'b0;
    repeat (300) @(negedge sys_clk);
    idle(2 * BIT);
    chk("glitch_busy", 32'(bus.rx_busy), 0);
    chk("glitch_valid_count", n_valid - v0, 0);
    chk("glitch_ferr_count", n_ferr - f0, 0);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(BIT);
    chk("badstop_ferr_count", n_ferr - f0, 1);
    chk("badstop_valid_count", n_valid - v0, 0);
    chk("badstop_data_kept", 32'(bus.rx_data), 'hA5);
    chk("badstop_busy", 32'(bus.rx_busy), 0);
    chk("badstop_drained", exp_q.size(), 0);

    v0 = n_valid; f0 = n_ferr;
    brk_e.is_err = 1'b1;
    brk_e.data = 8'h00;
    brk_e.perr = 1'b0;
    brk_e.lo = cyc + (NB - 1) * BIT;
    brk_e.hi = cyc + NB * BIT;
    exp_q.push_back(brk_e);
    bus.rx = 1'b0;
    repeat (20 * BIT) @(negedge sys_clk);
    chk("break_busy_while_low", 32'(bus.rx_busy), 1);
    idle(BIT);
    chk("break_one_ferr", n_ferr - f0, 1);
    chk("break_no_valid", n_valid - v0, 0);
    chk("break_data_kept", 32'(bus.rx_data), 'hA5);
    chk("break_busy", 32'(bus.rx_busy), 0);
    chk("break_drained", exp_q.size(), 0);

`ifndef UART_RX_PARITY_EN
    v0 = n_valid;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(BIT);
    chk("b2b_valid_count", n_valid - v0, 3);
    chk("b2b_last_data", 32'(bus.rx_data), 'h55);
    chk("b2b_drained", exp_q.size(), 0);
`endif

    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(part[i]);
    bus.rx = part[4];
    repeat (BIT / 2) @(negedge sys_clk);
    chk("busy_mid_frame", 32'(bus.rx_busy), 1);
    #2 rst_n = 1'b0;
    repeat (10) @(negedge sys_clk);
    bus.rx = 1'b1;
    #2 rst_n = 1'b1;
    idle(BIT);
    chk("reset_cleared_data", 32'(bus.rx_data), 0);
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h81, 1'b1, 1'b0);
    idle(BIT);
    chk("after_reset_data", 32'(bus.rx_data), 'h81);
    chk("after_reset_valid_count", n_valid - v0, 1);
    chk("after_reset_ferr_count", n_ferr - f0, 0);
    chk("after_reset_drained", exp_q.size(), 0);

    if (PAR_EN) begin
      v0 = n_valid; p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b1);
      idle(BIT);
      chk("par_bad_perr_count", n_perr - p0, 1);
      chk("par_bad_valid_count", n_valid - v0, 1);
      chk("par_bad_data", 32'(bus.rx_data), 'h07);
      v0 = n_valid; p0 = n_perr;
      send_frame(8'h07, 1'b1, 1'b0);
      idle(BIT);
      chk("par_good_perr_count", n_perr - p0, 0);
      chk("par_good_valid_count", n_valid - v0, 1);
      chk("par_drained", exp_q.size(), 0);
    end else chk("no_parity_pulses", n_perr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  CLK_FREQ, 100_000_000, sys_clk frequency in Hz
  BAUD, 115200, line bit rate
  OVERSAMPLE, 16, sample ticks per bit (even, >= 8)
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  sys_clk  input  1  system clock; reset rst_n, asynchronous, active-low; clock sys_clk
  rst_n  input  1  asynchronous active-low reset
  rx  input  1  asynchronous serial line, idle high
  rx_data  output  8  last received byte
  rx_valid  output  1  one-cycle pulse, rx_data updated
  frame_err  output  1  one-cycle pulse, stop bit sampled low
  parity_err  output  1  one-cycle pulse, parity mismatch
  rx_busy  output  1  high while a frame is in progress

Function
REQ-003 rx SHALL pass through a 2-flop synchronizer before any use; all sampling SHALL use the synchronized value.
REQ-004 Tick divisor DIV SHALL be floor(CLK_FREQ/(BAUD*OVERSAMPLE)); sample tick SHALL pulse one sys_clk every DIV cycles.
REQ-005 Tick counter SHALL be cleared on the start-edge detection cycle, so tick phase is frame-aligned.
REQ-006 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-007 IDLE -> START on a synchronized high-to-low transition; rx_busy SHALL go high in the same cycle.
REQ-008 START SHALL sample rx at tick OVERSAMPLE/2-1 (mid-bit); low -> DATA; high -> IDLE (glitch rejected, no flag).
REQ-009 DATA SHALL sample every OVERSAMPLE ticks after the mid-start sample; 8 bits, LSB first, into a shift register.
REQ-010 After bit 7: -> PARITY when parity is compiled in (REQ-018), else -> STOP.
REQ-011 STOP sample high: rx_data <= shift register and rx_valid pulses in the cycle after the sample; -> IDLE.
REQ-012 STOP sample low: frame_err pulses in the cycle after the sample; rx_data unchanged; rx_valid stays low; -> WAIT_IDLE.
REQ-013 WAIT_IDLE -> IDLE on the first synchronized high; a break (line held low) SHALL produce exactly one frame_err.
REQ-014 rx_busy SHALL be low in IDLE and high in all other states.
REQ-015 A start edge arriving immediately after the STOP mid-sample SHALL be accepted (back-to-back frames, no lost byte).
REQ-016 rx_data SHALL hold its value until the next valid frame.

Reset
REQ-017 On rst_n low: FSM -> IDLE; rx_data=0, rx_valid=0, frame_err=0, parity_err=0, rx_busy=0; counters cleared; synchronizer flops set to 1. Reset mid-frame SHALL discard the partial byte without pulses.

Configuration
REQ-018 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit; mismatch pulses parity_err together with rx_valid (data still delivered). Undefined: PARITY state and logic absent; parity_err tied 0; frame is 10 bits.

Structure
REQ-019 Package uart_pkg SHALL hold the FSM state enum, the data-width constant (8) and the DIV calculation function.
REQ-020 Sub-module uart_rx_baud_gen SHALL implement the tick divider with a synchronous clear input; everything else stays in uart_rx.

Verification (defaults: DIV=54, bit period 864 cycles)
REQ-021 Send 0xA5 (8N1) -> rx_valid one pulse, rx_data=0xA5, frame_err=0, rx_busy low after STOP.
REQ-022 rx low for 300 cycles then high -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-023 Send 0x3C with stop bit 0 -> frame_err one pulse, rx_valid 0, rx_data keeps previous value; 20-bit-time break -> exactly one frame_err.
REQ-024 Send 0x00, 0xFF, 0x55 back-to-back with no idle gap -> three rx_valid pulses with matching data, in order.
REQ-025 Assert rst_n low in bit 4 of a frame, release, send 0x81 -> only 0x81 reported; all outputs 0 during reset.
REQ-026 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> rx_valid and parity_err pulse together, rx_data=0x07; correct parity bit 1 -> parity_err 0.
